// File: rtl/regfile_storage.sv
// 32 x WIDTH register storage with one synchronous write port, a hardwired-zero
// register, and bit-transposed outputs that feed per-bit 32:1 read muxes.
module regfile_storage #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [4:0]            wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [32*WIDTH-1:0]   slices,
  output logic                  wr_ack,
  output logic [7:0]            wr_count
);

  localparam int NREGS = 32;
  localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

  logic [NREGS-1:0] dec_onehot;
  logic [NREGS-1:0] wr_sel;
  logic             accept;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             wr_ack_q,   wr_ack_d;
  logic [7:0]       wr_count_q, wr_count_d;

  // Write decode: one-hot address gated by wr_en; the zero register never loads.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    dec_onehot          = '0;
    dec_onehot[wr_addr] = 1'b1;
    wr_sel              = dec_onehot & {NREGS{wr_en}};
    wr_sel[ZERO_IDX]    = 1'b0;
    accept              = |wr_sel;
  end

  // Per-register hold mux: load on enable, otherwise recirculate.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = wr_sel[r] ? wr_data : regs_q[r];
      if (r == ZERO_REG) begin
        regs_d[r] = '0;
      end
    end
  end

  always_comb begin
    wr_ack_d   = accept;
    wr_count_d = wr_count_q + 8'(accept);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the storage array is cleared by reset because the architecture
      // defines every register as 0 after reset, not just the control state.
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      wr_ack_q   <= 1'b0;
      wr_count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples its _d value from before this edge.
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      wr_ack_q   <= wr_ack_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Transpose: slice b collects bit b of all 32 registers; the zero column is
  // forced low so it reads 0 even before the first reset.
  always_comb begin
    slices = '0;
    for (int b = 0; b < WIDTH; b++) begin
      for (int r = 0; r < NREGS; r++) begin
        slices[b*NREGS + r] = (r == ZERO_REG) ? 1'b0 : regs_q[r][b];
      end
    end
  end

  assign wr_ack   = wr_ack_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_storage.sv
// Randomized self-checking bench for regfile_storage against an array-based
// model of the architectural register state.
module tb_regfile_storage;

  localparam int WIDTH = 64;
  localparam int ZREG  = 31;

  logic                clk;
  logic                reset;
  logic                wr_en;
  logic [4:0]          wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic [32*WIDTH-1:0] slices;
  logic                wr_ack;
  logic [7:0]          wr_count;

  regfile_storage #(.WIDTH(WIDTH), .ZERO_REG(ZREG)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .slices   (slices),
    .wr_ack   (wr_ack),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register values, ack and count.
  logic [WIDTH-1:0] model_regs [32];
  logic             model_ack;
  int               model_cnt;

  int total_checks;
  int bad_checks;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] read_reg(input int r);
    logic [WIDTH-1:0] v;
    for (int b = 0; b < WIDTH; b++) v[b] = slices[b*32 + r];
    return v;
  endfunction

  task automatic check_state(input string tag);
    logic [31:0] exp_slice;
    int bsel [3];
    for (int r = 0; r < 32; r++)
      check($sformatf("%s reg%0d", tag, r), read_reg(r), model_regs[r]);
    check($sformatf("%s wr_ack", tag), WIDTH'(wr_ack), WIDTH'(model_ack));
    check($sformatf("%s wr_count", tag), WIDTH'(wr_count), WIDTH'(model_cnt));
    bsel[0] = 0;
    bsel[1] = WIDTH - 1;
    bsel[2] = int'($urandom_range(WIDTH - 1));
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 32; r++) exp_slice[r] = model_regs[r][bsel[k]];
      check($sformatf("%s slice%0d", tag, bsel[k]),
            WIDTH'(slices[bsel[k]*32 +: 32]), WIDTH'(exp_slice));
    end
  endtask

  // One clock: drive inputs, confirm no bypass before the edge, apply the
  // architectural rules to the model at the edge, then compare everything.
  task automatic cycle(input string tag, input logic rst_v, input logic en,
                       input logic [4:0] addr, input logic [WIDTH-1:0] data);
    bit acc;
    reset   = rst_v;
    wr_en   = en;
    wr_addr = addr;
    wr_data = data;
    #1;
    check($sformatf("%s pre-edge reg%0d", tag, addr), read_reg(addr), model_regs[addr]);
    @(posedge clk);
    if (!rst_v) begin
      for (int r = 0; r < 32; r++) model_regs[r] = '0;
      model_ack = 1'b0;
      model_cnt = 0;
    end else begin
      acc = en && (addr != 5'(ZREG));
      if (acc) model_regs[addr] = data;
      model_ack = acc;
      model_cnt = (model_cnt + (acc ? 1 : 0)) % 256;
    end
    #1;
    check_state(tag);
  endtask

  function automatic logic [WIDTH-1:0] rand_data();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int start_cnt;
    logic [4:0] a;
    total_checks = 0;
    bad_checks   = 0;
    for (int r = 0; r < 32; r++) model_regs[r] = '0;
    model_ack = 1'b0;
    model_cnt = 0;
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    @(negedge clk);

    // Reset dominates a concurrent write.
    cycle("reset0", 1'b0, 1'b1, 5'd5, {WIDTH{1'b1}});
    cycle("reset1", 1'b0, 1'b1, 5'd5, {WIDTH{1'b1}});

    for (int r = 0; r < 31; r++)
      cycle("wloop", 1'b1, 1'b1, 5'(r), 64'h0123_4567_89AB_CDE0 + 64'(r));
    check("wloop count", WIDTH'(wr_count), WIDTH'(31));

    cycle("zero_wr", 1'b1, 1'b1, 5'd31, 64'hDEAD_BEEF_DEAD_BEEF);
    check("zero_wr col31", read_reg(31), '0);

    cycle("hold_wr", 1'b1, 1'b1, 5'd7, 64'hA5A5_A5A5_A5A5_A5A5);
    for (int i = 0; i < 10; i++)
      cycle("hold", 1'b1, 1'b0, 5'($urandom), rand_data());
    check("hold reg7", read_reg(7), 64'hA5A5_A5A5_A5A5_A5A5);

    start_cnt = model_cnt;
    cycle("b2b1", 1'b1, 1'b1, 5'd3, 64'h1);
    check("b2b1 reg3", read_reg(3), 64'h1);
    cycle("b2b2", 1'b1, 1'b1, 5'd3, 64'h2);
    check("b2b2 reg3", read_reg(3), 64'h2);
    check("b2b count", WIDTH'(wr_count), WIDTH'((start_cnt + 2) % 256));

    // Counter wrap: 256 accepted writes bring the count back where it began.
    start_cnt = model_cnt;
    for (int i = 0; i < 256; i++)
      cycle("wrap", 1'b1, 1'b1, 5'($urandom_range(30)), rand_data());
    check("wrap count", WIDTH'(wr_count), WIDTH'(start_cnt));

    cycle("mid_rst", 1'b0, 1'b1, 5'd9, 64'hFEED_FACE_0BAD_F00D);
    check("mid_rst reg9", read_reg(9), '0);
    check("mid_rst count", WIDTH'(wr_count), '0);
    check("mid_rst ack", WIDTH'(wr_ack), '0);
    cycle("resume", 1'b1, 1'b1, 5'd9, 64'h0000_0000_0000_0099);
    check("resume reg9", read_reg(9), 64'h99);

    // Fully random traffic including zero-register writes and sporadic reset.
    for (int i = 0; i < 300; i++) begin
      a = 5'($urandom);
      cycle("rand", ($urandom_range(31) != 0), ($urandom_range(3) != 0), a, rand_data());
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
